// File: rtl/arb_pkg.sv
// Shared definitions for the mux bus arbiter: mux select codes, FSM states
// and small index helpers used by the arbiter top and its pick logic.
package arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    localparam logic [1:0] SEL_D0   = 2'b00;
    localparam logic [1:0] SEL_D1   = 2'b01;
    localparam logic [1:0] SEL_D2   = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // One-hot grant vector for a requester index; out-of-range gives no owner.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Mux select code for a requester index; out-of-range selects nothing.
    function automatic logic [1:0] sel_of(input logic [1:0] idx);
        case (idx)
            2'd0:    sel_of = SEL_D0;
            2'd1:    sel_of = SEL_D1;
            2'd2:    sel_of = SEL_D2;
            default: sel_of = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority requester pick: scans last+1, last+2, last+3 (mod 3)
// and reports the first requester found.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last,
    output logic               valid,
    output logic [1:0]         idx
);

    // Scan requesters starting just after the previous owner.
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            int unsigned cand;
            cand = (int'(last) + k) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = 2'(cand);
            end
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit 3-to-1 result mux.
// Sequence per owner: IDLE -> GRANT -> TURN (bus turnaround) -> IDLE.
// Optional hog revoke is enabled by defining ARB_TIMEOUT_EN; the default
// build has unbounded ownership and timeout tied low.
module mux_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] done,
    output logic [2:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    arb_state_t        state;
    logic [1:0]        last_owner;
    logic [TURN_W-1:0] turn_cnt;

    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic              owner_release;

    rr_pick u_pick (
        .req   (req),
        .last  (last_owner),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // grant is one-hot in GRANT, so masking with it isolates the owner's bits.
    assign owner_release = (|(done & grant)) | ~(|(req & grant));

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic              others_waiting;
    logic              revoke;

    assign others_waiting = |(req & ~grant);
    assign revoke         = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && others_waiting;
`else
    assign timeout = 1'b0;
`endif

    // Arbitration FSM with registered grant/sel/busy/timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            sel        <= SEL_NONE;
            busy       <= 1'b0;
            last_owner <= 2'd2;
            turn_cnt   <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout    <= 1'b0;
            hold_cnt   <= '0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state <= ST_GRANT;
                        grant <= onehot(pick_idx);
                        sel   <= sel_of(pick_idx);
                        busy  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        grant <= '0;
                        sel   <= SEL_NONE;
                        busy  <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    // sel carries the owner index while granted.
                    if (owner_release) begin
                        state      <= ST_TURN;
                        grant      <= '0;
                        sel        <= SEL_NONE;
                        last_owner <= sel;
                        turn_cnt   <= TURN_W'(TURN_CYC - 1);
`ifdef ARB_TIMEOUT_EN
                    end else if (revoke) begin
                        state      <= ST_TURN;
                        grant      <= '0;
                        sel        <= SEL_NONE;
                        last_owner <= sel;
                        turn_cnt   <= TURN_W'(TURN_CYC - 1);
                        timeout    <= 1'b1;
                    end else if (hold_cnt != HOLD_W'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 1'b1;
`endif
                    end
                end

                ST_TURN: begin
                    if (turn_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    sel   <= SEL_NONE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed self-checking bench for mux_bus_arbiter (TURN_CYC=1, MAX_HOLD=4).
// Timeout scenarios are exercised when ARB_TIMEOUT_EN is defined.
module tb_mux_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int unsigned n_checks;
    int unsigned n_fail;

    mux_bus_arbiter #(
        .TURN_CYC (1),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 3'b000;
        done = 3'b000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 3'b000;
        done = 3'b000;
        step();
        step();
        rst = 1'b0;
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b want 000", grant); end
        n_checks++; if (sel !== 2'b11) begin n_fail++; $display("FAIL reset_sel: got %b want 11", sel); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_single();
        req = 3'b001;
        step();
        n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL single_grant: got %b want 001", grant); end
        n_checks++; if (sel !== 2'b00) begin n_fail++; $display("FAIL single_sel: got %b want 00", sel); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
        done = 3'b001;
        step();
        done = 3'b000;
        req  = 3'b000;
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL single_release_grant: got %b want 000", grant); end
        n_checks++; if (sel !== 2'b11) begin n_fail++; $display("FAIL single_release_sel: got %b want 11", sel); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_turn_busy: got %b want 1", busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        step();
        n_checks++; if (sel !== 2'b11) begin n_fail++; $display("FAIL single_idle_sel: got %b want 11", sel); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_grant [4];
        logic [1:0] exp_sel   [4];
        exp_grant[0] = 3'b001; exp_sel[0] = 2'b00;
        exp_grant[1] = 3'b010; exp_sel[1] = 2'b01;
        exp_grant[2] = 3'b100; exp_sel[2] = 2'b10;
        exp_grant[3] = 3'b001; exp_sel[3] = 2'b00;
        do_reset();
        req = 3'b111;
        step();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (grant !== exp_grant[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, exp_grant[i]); end
            n_checks++; if (sel !== exp_sel[i]) begin n_fail++; $display("FAIL rr_sel[%0d]: got %b want %b", i, sel, exp_sel[i]); end
            step();
            n_checks++; if (grant !== exp_grant[i]) begin n_fail++; $display("FAIL rr_hold[%0d]: got %b want %b", i, grant, exp_grant[i]); end
            done = exp_grant[i];
            step();
            done = 3'b000;
            n_checks++; if (grant !== 3'b000 || sel !== 2'b11 || busy !== 1'b1) begin n_fail++; $display("FAIL rr_gap1[%0d]: got grant=%b sel=%b busy=%b want 000/11/1", i, grant, sel, busy); end
            step();
            n_checks++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_gap2[%0d]: got grant=%b busy=%b want 000/0", i, grant, busy); end
            step();
        end
        req = 3'b000;
        step();
        step();
        n_checks++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got grant=%b busy=%b want 000/0", grant, busy); end
    endtask

    task automatic test_ignore_done();
        do_reset();
        req = 3'b010;
        step();
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL ign_grant: got %b want 010", grant); end
        req  = 3'b011;
        done = 3'b101;
        step();
        done = 3'b000;
        n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL ign_other_done: got %b want 010", grant); end
        step();
        n_checks++; if (grant !== 3'b010 || sel !== 2'b01) begin n_fail++; $display("FAIL ign_holdoff: got grant=%b sel=%b want 010/01", grant, sel); end
        req = 3'b001;
        step();
        n_checks++; if (grant !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL ign_drop_release: got grant=%b busy=%b want 000/1", grant, busy); end
        step();
        n_checks++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL ign_idle: got grant=%b busy=%b want 000/0", grant, busy); end
        step();
        n_checks++; if (grant !== 3'b001 || sel !== 2'b00) begin n_fail++; $display("FAIL ign_next_owner: got grant=%b sel=%b want 001/00", grant, sel); end
        req  = 3'b000;
        done = 3'b001;
        step();
        done = 3'b000;
        n_checks++; if (grant !== 3'b000 || busy !== 1'b1) begin n_fail++; $display("FAIL ign_drop_and_done: got grant=%b busy=%b want 000/1", grant, busy); end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_single_release: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b100;
        step();
        n_checks++; if (grant !== 3'b100 || sel !== 2'b10) begin n_fail++; $display("FAIL rmg_grant: got grant=%b sel=%b want 100/10", grant, sel); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (grant !== 3'b000 || sel !== 2'b11 || busy !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rmg_reset: got grant=%b sel=%b busy=%b timeout=%b want 000/11/0/0", grant, sel, busy, timeout); end
        req = 3'b101;
        step();
        n_checks++; if (grant !== 3'b001 || sel !== 2'b00) begin n_fail++; $display("FAIL rmg_first: got grant=%b sel=%b want 001/00", grant, sel); end
        req = 3'b000;
        step();
        step();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 3'b011;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (grant !== 3'b001 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_hold[%0d]: got grant=%b timeout=%b want 001/0", i, grant, timeout); end
        end
        step();
        n_checks++; if (grant !== 3'b000 || timeout !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL to_revoke: got grant=%b timeout=%b busy=%b want 000/1/1", grant, timeout, busy); end
        step();
        n_checks++; if (timeout !== 1'b0 || grant !== 3'b000) begin n_fail++; $display("FAIL to_pulse: got timeout=%b grant=%b want 0/000", timeout, grant); end
        step();
        n_checks++; if (grant !== 3'b010 || sel !== 2'b01) begin n_fail++; $display("FAIL to_next: got grant=%b sel=%b want 010/01", grant, sel); end
        do_reset();
        req = 3'b001;
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (grant !== 3'b001 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_solo[%0d]: got grant=%b timeout=%b want 001/0", i, grant, timeout); end
        end
        req = 3'b000;
        step();
        step();
    endtask

    task automatic test_done_on_revoke();
        do_reset();
        req = 3'b011;
        step();
        step();
        step();
        step();
        done = 3'b001;
        step();
        done = 3'b000;
        n_checks++; if (grant !== 3'b000 || timeout !== 1'b0) begin n_fail++; $display("FAIL dor_release: got grant=%b timeout=%b want 000/0", grant, timeout); end
        step();
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL dor_after: got timeout=%b want 0", timeout); end
        req = 3'b000;
        step();
        step();
    endtask
`else
    task automatic test_timeout_disabled();
        do_reset();
        req = 3'b011;
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (grant !== 3'b001 || timeout !== 1'b0) begin n_fail++; $display("FAIL notimeout[%0d]: got grant=%b timeout=%b want 001/0", i, grant, timeout); end
        end
        req = 3'b000;
        step();
        step();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        req  = 3'b000;
        done = 3'b000;
        test_reset();
        test_single();
        test_round_robin();
        test_ignore_done();
        test_reset_mid_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
        test_done_on_revoke();
`else
        test_timeout_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
